button_event_arbiter: RTL and testbench

//   Front end for all Tamagotchi push-buttons. Each raw button is synchronised,

---
 rtl/button_event_arbiter.sv | 121 ++++++++++++
 tb/tb_button_event_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Push-button front end: synchronise, debounce and detect presses, then serialise
// them round-robin into a small event FIFO drained through a valid/ready handshake.
module button_event_arbiter #(
  parameter int N_BTN           = 3,
  parameter int ID_W            = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]  sync_a, sync_b, level_prev, press, pend, grant;
  logic [CNT_W-1:0]  db_cnt [N_BTN];
  logic [ID_W-1:0]   rr, grant_id, arb_idx;
  logic              grant_any, fifo_full, push, pop;
  logic [ID_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_FW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level  <= '0;
      level_prev <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
    end else begin
      level_prev <= btn_level;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_b[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_level[i] <= sync_b[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press       = btn_level & ~level_prev;
  assign evt_overrun = |(press & pend & ~grant);
  assign fifo_full   = (count == CNT_FW'(FIFO_DEPTH));

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= N_BTN; k++) begin
        arb_idx = ID_W'((int'(rr) + k) % N_BTN);
        if (!grant_any && pend[arb_idx]) begin
          grant_any = 1'b1;
          grant_id  = arb_idx;
        end
      end
    end
  end

  assign grant = grant_any ? (N_BTN'(1) << grant_id) : '0;

  // A press coinciding with its own grant keeps the button pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      rr   <= ID_W'(N_BTN - 1);
    end else begin
      pend <= (pend & ~grant) | press;
      if (grant_any) rr <= grant_id;
    end
  end

  assign push = grant_any;
  assign pop  = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_FW'(1);
        2'b01:   count <= count - CNT_FW'(1);
        default: count <= count;
      endcase
    end
  end

  assign evt_valid = (count != '0);
  assign evt_id    = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: vector table plus hand-written
// sequences, with a scoreboard queue of expected event ids.
module tb_button_event_arbiter;

  localparam int N_BTN = 3;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready;
  logic             evt_overrun;

  int checks   = 0;
  int failures = 0;
  int rise_cnt [N_BTN];
  int overrun_cnt = 0;
  int event_cnt   = 0;
  logic [ID_W-1:0]  exp_q [$];
  logic [N_BTN-1:0] level_prev = '0;

  typedef struct {
    logic [N_BTN-1:0] mask;
    int               hold;
    logic [N_BTN-1:0] exp_rise;
    int               n_ids;
    logic [5:0]       ids;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  button_event_arbiter #(
    .N_BTN(N_BTN), .ID_W(ID_W), .DEBOUNCE_CYCLES(8), .CNT_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .evt_overrun(evt_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard side: every accepted handshake is compared with the queue head.
  task automatic monitorLoop();
    logic [ID_W-1:0] exp_id;
    forever begin
      @(negedge clk);
      for (int b = 0; b < N_BTN; b++)
        if (btn_level[b] && !level_prev[b]) rise_cnt[b]++;
      level_prev = btn_level;
      if (evt_overrun) overrun_cnt++;
      if (evt_valid && evt_ready) begin
        event_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got id %0d expected no event", evt_id);
        end else begin
          exp_id = exp_q.pop_front();
          checkOutput("event_id", int'(evt_id), int'(exp_id));
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int j = 0; j < v.n_ids; j++) exp_q.push_back(v.ids[2*j +: 2]);
    btn_in = v.mask;
    repeat (v.hold) tick();
    btn_in = '0;
    repeat (30) tick();
  endtask

  task automatic pressBtn(input int b, input bit expect_event);
    if (expect_event) exp_q.push_back(ID_W'(b));
    btn_in[b] = 1'b1;
    repeat (12) tick();
    btn_in[b] = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    int base [N_BTN];
    int ev_base;

    vecs[0] = '{mask: 3'b001, hold: 7,  exp_rise: 3'b000, n_ids: 0, ids: 6'd0};
    vecs[1] = '{mask: 3'b010, hold: 1,  exp_rise: 3'b000, n_ids: 0, ids: 6'd0};
    vecs[2] = '{mask: 3'b110, hold: 20, exp_rise: 3'b110, n_ids: 2, ids: {2'd0, 2'd2, 2'd1}};
    vecs[3] = '{mask: 3'b011, hold: 20, exp_rise: 3'b011, n_ids: 2, ids: {2'd0, 2'd1, 2'd0}};
    vecs[4] = '{mask: 3'b111, hold: 20, exp_rise: 3'b111, n_ids: 3, ids: {2'd1, 2'd0, 2'd2}};
    vecs[5] = '{mask: 3'b001, hold: 8,  exp_rise: 3'b001, n_ids: 1, ids: {4'd0, 2'd0}};

    for (int b = 0; b < N_BTN; b++) rise_cnt[b] = 0;
    btn_in    = '0;
    evt_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    fork
      monitorLoop();
    join_none

    repeat (3) tick();
    checkOutput("reset_valid", int'(evt_valid), 0);
    checkOutput("reset_id", int'(evt_id), 0);
    checkOutput("reset_overrun", int'(evt_overrun), 0);
    checkOutput("reset_level", int'(btn_level), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Bouncing contact followed by a solid press of button 0.
    exp_q.push_back(2'd0);
    for (int r = 0; r < 5; r++) begin
      btn_in[0] = 1'b1;
      repeat (3) tick();
      btn_in[0] = 1'b0;
      repeat (3) tick();
    end
    checkOutput("bounce_no_rise", rise_cnt[0], 0);
    btn_in[0] = 1'b1;
    repeat (20) tick();
    btn_in[0] = 1'b0;
    repeat (30) tick();
    checkOutput("bounce_one_rise", rise_cnt[0], 1);
    checkOutput("bounce_drained", exp_q.size(), 0);
    checkOutput("bounce_events", event_cnt, 1);

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < N_BTN; b++) base[b] = rise_cnt[b];
      applyStimulus(vecs[i]);
      for (int b = 0; b < N_BTN; b++)
        checkOutput($sformatf("v%0d_rise%0d", i, b), rise_cnt[b] - base[b],
                    int'(vecs[i].exp_rise[b]));
      checkOutput($sformatf("v%0d_drained", i), exp_q.size(), 0);
      checkOutput($sformatf("v%0d_level", i), int'(btn_level), 0);
      checkOutput($sformatf("v%0d_valid", i), int'(evt_valid), 0);
    end

    // Fill the FIFO with button 0, coalesce the overflow press, then drain.
    evt_ready = 1'b0;
    ev_base   = event_cnt;
    for (int p = 0; p < 5; p++) pressBtn(0, 1'b1);
    checkOutput("full_valid", int'(evt_valid), 1);
    checkOutput("full_head", int'(evt_id), 0);
    checkOutput("full_no_overrun", overrun_cnt, 0);
    pressBtn(0, 1'b0);
    checkOutput("overrun_pulse", overrun_cnt, 1);
    evt_ready = 1'b1;
    repeat (20) tick();
    checkOutput("overrun_events", event_cnt - ev_base, 5);
    checkOutput("overrun_drained", exp_q.size(), 0);
    checkOutput("overrun_valid", int'(evt_valid), 0);

    // Full FIFO with button 2 pending: it must land behind the queued entries.
    evt_ready = 1'b0;
    ev_base   = event_cnt;
    pressBtn(1, 1'b1);
    pressBtn(2, 1'b1);
    pressBtn(0, 1'b1);
    pressBtn(1, 1'b1);
    pressBtn(2, 1'b1);
    checkOutput("tail_head", int'(evt_id), 1);
    evt_ready = 1'b1;
    repeat (20) tick();
    checkOutput("tail_events", event_cnt - ev_base, 5);
    checkOutput("tail_drained", exp_q.size(), 0);

    // Asynchronous reset with two events queued discards them.
    evt_ready = 1'b0;
    pressBtn(0, 1'b0);
    pressBtn(1, 1'b0);
    checkOutput("pre_reset_valid", int'(evt_valid), 1);
    ev_base = event_cnt;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", int'(evt_valid), 0);
    checkOutput("async_reset_id", int'(evt_id), 0);
    repeat (2) tick();
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    repeat (20) tick();
    checkOutput("post_reset_events", event_cnt - ev_base, 0);
    checkOutput("post_reset_valid", int'(evt_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
